free_list: RTL and testbench

//  N-way circular FIFO of free physical register indices. It is the supply end of the ROB
//  t/t_old interface:
//  - Dispatch pops up to N tags to use as new t.
//  - Retirement pushes the retiring t_old tags back.
//  - Branch recovery restores the head pointer from a checkpoint taken at branch dispatch.

---
 rtl/free_list.sv | 106 ++++++++++
 tb/tb_free_list.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/free_list.sv
// Circular FIFO of free physical register tags. Dispatch pops from head, retirement pushes
// freed t_old tags at tail, and branch recovery rewinds head to a checkpoint.
module free_list #(
    parameter int N        = 3,
    parameter int NUM_PHYS = 64,
    parameter int NUM_ARCH = 32,
    parameter int DEPTH    = NUM_PHYS - NUM_ARCH,
    localparam int LOG_DEPTH = $clog2(DEPTH),
    localparam int PHYS_W    = $clog2(NUM_PHYS),
    localparam int CNT_W     = $clog2(N + 1)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [CNT_W-1:0]             num_dispatch,
    input  logic [N-1:0][PHYS_W-1:0]     retire_t_old,
    input  logic [N-1:0]                 retire_valid,
    input  logic [CNT_W-1:0]             num_retired,
    input  logic                         br_en,
    input  logic [LOG_DEPTH:0]           br_head,
    output logic [N-1:0][PHYS_W-1:0]     free_regs,
    output logic [CNT_W-1:0]             num_avail,
    output logic [LOG_DEPTH:0]           out_head
);

    localparam logic [LOG_DEPTH:0] N_PTR = (LOG_DEPTH + 1)'(N);

    logic [PHYS_W-1:0]    entries_reg [DEPTH];
    logic [LOG_DEPTH:0]   head_reg;
    logic [LOG_DEPTH:0]   tail_reg;
    logic [LOG_DEPTH:0]   head_next;
    logic [LOG_DEPTH:0]   tail_next;
    logic [LOG_DEPTH:0]   count;
    logic [CNT_W-1:0]     eff_pop;
    logic [CNT_W-1:0]     push_cnt;
    logic [N-1:0]         lane_en;
    logic [CNT_W-1:0]     lane_ofs  [N];
    logic [LOG_DEPTH-1:0] lane_addr [N];

    // The wrap bit makes tail - head exact for both empty and full.
    assign count     = tail_reg - head_reg;
    assign num_avail = (count >= N_PTR) ? CNT_W'(N) : CNT_W'(count);
    assign out_head  = head_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            logic [LOG_DEPTH-1:0] peek_idx;
            assign peek_idx      = head_reg[LOG_DEPTH-1:0] + LOG_DEPTH'(gi);
            assign free_regs[gi] = entries_reg[peek_idx];
            assign lane_en[gi]   = retire_valid[gi] && (CNT_W'(gi) < num_retired);
        end
    endgenerate

    // Compact valid retire lanes so that skipped lanes leave no hole in the FIFO.
    always_comb begin
        push_cnt = '0;
        for (int i = 0; i < N; i++) begin
            lane_ofs[i]  = push_cnt;
            lane_addr[i] = tail_reg[LOG_DEPTH-1:0] + LOG_DEPTH'(push_cnt);
            push_cnt     = push_cnt + CNT_W'(lane_en[i]);
        end
    end

    always_comb begin
        eff_pop   = '0;
        head_next = head_reg;
        if (br_en) begin
            head_next = br_head;
        end else begin
            eff_pop   = (num_dispatch > num_avail) ? num_avail : num_dispatch;
            head_next = head_reg + (LOG_DEPTH + 1)'(eff_pop);
        end
        tail_next = tail_reg + (LOG_DEPTH + 1)'(push_cnt);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_reg[i] <= PHYS_W'(NUM_ARCH + i);
            end
            head_reg <= '0;
            tail_reg <= {1'b1, {LOG_DEPTH{1'b0}}};
        end else begin
            for (int i = 0; i < N; i++) begin
                if (lane_en[i]) begin
                    entries_reg[lane_addr[i]] <= retire_t_old[i];
                end
            end
            head_reg <= head_next;
            tail_reg <= tail_next;
        end
    end

    logic [LOG_DEPTH+1:0] count_after;
    assign count_after = {1'b0, count} - (LOG_DEPTH + 2)'(eff_pop) + (LOG_DEPTH + 2)'(push_cnt);

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (br_en || (num_dispatch <= num_avail));
            assert (br_en || (count_after <= (LOG_DEPTH + 2)'(DEPTH)));
            // lane_ofs is only observed here; it documents each lane's slot offset.
            assert (lane_ofs[0] == '0);
        end
    end

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list (N=3, 64 phys, 32 arch): reset, drain, push, branch recovery,
// and long wrap-around traffic against a FIFO-order scoreboard.
module tb_free_list;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       num_dispatch;
    logic [2:0][5:0]  retire_t_old;
    logic [2:0]       retire_valid;
    logic [1:0]       num_retired;
    logic             br_en;
    logic [5:0]       br_head;
    logic [2:0][5:0]  free_regs;
    logic [1:0]       num_avail;
    logic [5:0]       out_head;

    int checks = 0;
    int errors = 0;

    logic [5:0] free_q[$];
    logic [5:0] pending_q[$];
    logic [5:0] map_tbl[32];
    logic [5:0] exp_head;

    free_list #(.N(3), .NUM_PHYS(64), .NUM_ARCH(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .num_dispatch (num_dispatch),
        .retire_t_old (retire_t_old),
        .retire_valid (retire_valid),
        .num_retired  (num_retired),
        .br_en        (br_en),
        .br_head      (br_head),
        .free_regs    (free_regs),
        .num_avail    (num_avail),
        .out_head     (out_head)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        num_dispatch = 2'd0;
        retire_t_old = '0;
        retire_valid = 3'b000;
        num_retired  = 2'd0;
        br_en        = 1'b0;
        br_head      = 6'd0;
    endtask

    task automatic model_reset();
        free_q.delete();
        pending_q.delete();
        for (int i = 0; i < 32; i++) begin
            free_q.push_back(6'(32 + i));
            map_tbl[i] = 6'(i);
        end
        exp_head = 6'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        step();
        step();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            $display("reset/idle cycle %0d: free_regs=%h avail=%0d head=%0d", k, free_regs, num_avail, out_head);
            checks++;
            if (free_regs !== {6'd34, 6'd33, 6'd32}) begin
                errors++;
                $display("FAIL reset_free_regs: got %h expected %h", free_regs, {6'd34, 6'd33, 6'd32});
            end
            checks++;
            if (num_avail !== 2'd3) begin
                errors++;
                $display("FAIL reset_num_avail: got %0d expected 3", num_avail);
            end
            checks++;
            if (out_head !== 6'd0) begin
                errors++;
                $display("FAIL reset_out_head: got %0d expected 0", out_head);
            end
            step();
        end
    endtask

    task automatic test_drain();
        num_dispatch = 2'd3;
        for (int k = 0; k < 10; k++) begin
            $display("drain cycle %0d: pop 3 free_regs[0]=%0d", k, free_regs[0]);
            checks++;
            if (free_regs[0] !== 6'(32 + 3 * k) || num_avail !== 2'd3) begin
                errors++;
                $display("FAIL drain_peek: got tag %0d avail %0d expected tag %0d avail 3",
                         free_regs[0], num_avail, 32 + 3 * k);
            end
            step();
        end
        num_dispatch = 2'd2;
        checks++;
        if (num_avail !== 2'd2 || free_regs[0] !== 6'd62 || free_regs[1] !== 6'd63 || out_head !== 6'd30) begin
            errors++;
            $display("FAIL drain_tail: got avail %0d tags %0d,%0d head %0d expected 2 62,63 30",
                     num_avail, free_regs[0], free_regs[1], out_head);
        end
        step();
        num_dispatch = 2'd0;
        $display("drain final pop 2: avail=%0d head=%0d", num_avail, out_head);
        checks++;
        if (num_avail !== 2'd0 || out_head !== 6'd32) begin
            errors++;
            $display("FAIL drain_empty: got avail %0d head %0d expected 0 32", num_avail, out_head);
        end
    endtask

    task automatic test_push_no_bypass();
        retire_t_old = {6'd7, 6'd9, 6'd5};
        retire_valid = 3'b101;
        num_retired  = 2'd3;
        checks++;
        if (num_avail !== 2'd0) begin
            errors++;
            $display("FAIL push_no_bypass: got avail %0d expected 0", num_avail);
        end
        step();
        drive_idle();
        $display("push {5,9,7} mask 101: avail=%0d free_regs=%h", num_avail, free_regs);
        checks++;
        if (num_avail !== 2'd2 || free_regs[0] !== 6'd5 || free_regs[1] !== 6'd7) begin
            errors++;
            $display("FAIL push_compact: got avail %0d tags %0d,%0d expected 2 5,7",
                     num_avail, free_regs[0], free_regs[1]);
        end
        checks++;
        if (out_head !== 6'd32) begin
            errors++;
            $display("FAIL push_head: got %0d expected 32", out_head);
        end
    endtask

    task automatic test_branch_recovery();
        logic [5:0] ckpt;
        reset = 1'b1;
        drive_idle();
        step();
        reset = 1'b0;
        num_dispatch = 2'd3; step();
        num_dispatch = 2'd3; step();
        num_dispatch = 2'd2; step();
        num_dispatch = 2'd0;
        ckpt = out_head;
        checks++;
        if (free_regs !== {6'd42, 6'd41, 6'd40} || out_head !== 6'd8) begin
            errors++;
            $display("FAIL br_checkpoint: got tags %h head %0d expected %h 8", free_regs, out_head, {6'd42, 6'd41, 6'd40});
        end
        num_dispatch = 2'd3;
        step();
        step();
        checks++;
        if (free_regs[0] !== 6'd46 || out_head !== 6'd14) begin
            errors++;
            $display("FAIL br_advance: got tag %0d head %0d expected 46 14", free_regs[0], out_head);
        end
        br_en   = 1'b1;
        br_head = ckpt;
        step();
        drive_idle();
        $display("branch restore to %0d: head=%0d free_regs=%h", ckpt, out_head, free_regs);
        checks++;
        if (free_regs !== {6'd42, 6'd41, 6'd40} || out_head !== 6'd8 || num_avail !== 2'd3) begin
            errors++;
            $display("FAIL br_restore: got tags %h head %0d avail %0d expected %h 8 3",
                     free_regs, out_head, num_avail, {6'd42, 6'd41, 6'd40});
        end
    endtask

    task automatic test_branch_with_retire();
        num_dispatch = 2'd3;
        for (int k = 0; k < 4; k++) step();
        checks++;
        if (out_head !== 6'd20 || free_regs[0] !== 6'd52) begin
            errors++;
            $display("FAIL brr_pre: got head %0d tag %0d expected 20 52", out_head, free_regs[0]);
        end
        br_en        = 1'b1;
        br_head      = 6'd8;
        retire_t_old = {6'd13, 6'd12, 6'd11};
        retire_valid = 3'b111;
        num_retired  = 2'd2;
        step();
        drive_idle();
        $display("branch restore with retire {11,12}: head=%0d free_regs=%h", out_head, free_regs);
        checks++;
        if (out_head !== 6'd8 || free_regs !== {6'd42, 6'd41, 6'd40}) begin
            errors++;
            $display("FAIL brr_restore: got head %0d tags %h expected 8 %h", out_head, free_regs, {6'd42, 6'd41, 6'd40});
        end
        // Count after restore is 32 + 2 - 8 = 26: 24 pops then exactly the two retired tags.
        num_dispatch = 2'd3;
        for (int k = 0; k < 8; k++) step();
        num_dispatch = 2'd0;
        checks++;
        if (out_head !== 6'd32 || num_avail !== 2'd2 || free_regs[0] !== 6'd11 || free_regs[1] !== 6'd12) begin
            errors++;
            $display("FAIL brr_count: got head %0d avail %0d tags %0d,%0d expected 32 2 11,12",
                     out_head, num_avail, free_regs[0], free_regs[1]);
        end
        num_dispatch = 2'd2;
        step();
        num_dispatch = 2'd0;
        checks++;
        if (num_avail !== 2'd0 || out_head !== 6'd34) begin
            errors++;
            $display("FAIL brr_empty: got avail %0d head %0d expected 0 34", num_avail, out_head);
        end
    endtask

    task automatic run_traffic(input int ncyc);
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            int         exp_avail;
            int         pop;
            int         nr;
            logic [2:0] vmask;
            logic [5:0] push_tags[$];
            exp_avail = (free_q.size() < 3) ? free_q.size() : 3;
            checks++;
            if (num_avail !== 2'(exp_avail) || out_head !== exp_head) begin
                errors++;
                $display("FAIL traffic_state cycle %0d: got avail %0d head %0d expected %0d %0d",
                         cyc, num_avail, out_head, exp_avail, exp_head);
            end
            for (int i = 0; i < exp_avail; i++) begin
                checks++;
                if (free_regs[i] !== free_q[i]) begin
                    errors++;
                    $display("FAIL traffic_tag cycle %0d lane %0d: got %0d expected %0d",
                             cyc, i, free_regs[i], free_q[i]);
                end
            end
            pop   = cyc % 4;
            if (pop > exp_avail) pop = exp_avail;
            nr    = (cyc * 5 + 1) % 4;
            vmask = 3'((cyc * 3) ^ (cyc >> 1));
            for (int i = 0; i < 3; i++) begin
                retire_t_old[i] = 6'(63 - i * 7);
                if (i < nr && vmask[i]) begin
                    if (pending_q.size() > 0) begin
                        retire_t_old[i] = pending_q.pop_front();
                        push_tags.push_back(retire_t_old[i]);
                    end else begin
                        vmask[i] = 1'b0;
                    end
                end
            end
            for (int i = 0; i < pop; i++) begin
                int r;
                void'(free_q.pop_front());
                r = (cyc * 7 + i * 13) % 32;
                pending_q.push_back(map_tbl[r]);
                map_tbl[r] = free_regs[i];
            end
            foreach (push_tags[j]) free_q.push_back(push_tags[j]);
            exp_head     = exp_head + 6'(pop);
            num_dispatch = 2'(pop);
            retire_valid = vmask;
            num_retired  = 2'(nr);
            $display("traffic cycle %0d: pop %0d push %0d head %0d", cyc, pop, push_tags.size(), out_head);
            step();
        end
        drive_idle();
    endtask

    task automatic test_wrap_traffic();
        int seen[64];
        int bad;
        reset = 1'b1;
        drive_idle();
        step();
        reset = 1'b0;
        model_reset();
        run_traffic(40);
        // Reset lands with busy inputs and must still win.
        reset        = 1'b1;
        num_dispatch = 2'd3;
        retire_t_old = {6'd1, 6'd2, 6'd3};
        retire_valid = 3'b111;
        num_retired  = 2'd3;
        br_en        = 1'b1;
        br_head      = 6'd5;
        step();
        reset = 1'b0;
        drive_idle();
        $display("mid-traffic reset: free_regs=%h avail=%0d head=%0d", free_regs, num_avail, out_head);
        checks++;
        if (free_regs !== {6'd34, 6'd33, 6'd32} || num_avail !== 2'd3 || out_head !== 6'd0) begin
            errors++;
            $display("FAIL midreset_state: got tags %h avail %0d head %0d expected %h 3 0",
                     free_regs, num_avail, out_head, {6'd34, 6'd33, 6'd32});
        end
        model_reset();
        run_traffic(90);
        for (int t = 0; t < 64; t++) seen[t] = 0;
        foreach (free_q[j])    seen[free_q[j]]++;
        foreach (pending_q[j]) seen[pending_q[j]]++;
        for (int r = 0; r < 32; r++) seen[map_tbl[r]]++;
        bad = 0;
        for (int t = 0; t < 64; t++) if (seen[t] != 1) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL tag_conservation: got %0d tags not held exactly once, expected 0", bad);
        end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_drain();
        test_push_no_bypass();
        test_branch_recovery();
        test_branch_with_retire();
        test_wrap_traffic();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
